// File: rtl/conv_window_gen_pkg.sv
// Shared types and window-indexing helpers for the 3x3 window generator.
package conv_pkg;

  localparam int unsigned DW = 8;

  typedef logic [DW-1:0] pixel_t;
  typedef pixel_t [8:0]  window_t;

  localparam int unsigned WIN_ROWS = 3;
  localparam int unsigned WIN_COLS = 3;

  // Flat element index of window position (r, c); r=0 is the oldest row
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * WIN_COLS + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_delay.sv
// Enable-gated row delay: a circular RAM with one pointer, read-before-write,
// so dout is the sample written exactly DEPTH enabled beats ago.
module conv_line_delay #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;

  assign dout = mem[ptr];

  // Pointer walks the ring once per enabled beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  // Storage overwrites the slot just read; contents need no reset
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 window generator for a raster-order pixel stream (valid-convolution mode).
// Optional window counter output enabled by defining CONV_WIN_CNT_EN.
module conv_window_gen #(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned ROW_W = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [DW-1:0]   i_data,
  input  logic            i_last,
  output logic [9*DW-1:0] o_window,
  output logic            o_valid,
  output logic            o_last,
  output logic            o_frame_done
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [ROW_W+7:0] o_win_count
`endif
);

  import conv_pkg::*;

  localparam int unsigned CW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic [CW-1:0]    col;
  logic [ROW_W-1:0] row;
  logic [DW-1:0]    tap0, tap1, tap2;
  logic [DW-1:0]    sr [WIN_ROWS][WIN_COLS];
  logic             emit;

  assign tap0 = i_data;
  assign emit = i_valid && (row >= ROW_W'(2)) && (col >= CW'(2));

  conv_line_delay #(.DEPTH(IMG_W), .DW(DW)) u_dly_row1 (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (i_valid),
    .din  (tap0),
    .dout (tap1)
  );

  conv_line_delay #(.DEPTH(IMG_W), .DW(DW)) u_dly_row2 (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (i_valid),
    .din  (tap1),
    .dout (tap2)
  );

  // Raster position; i_last restarts at (0,0), row saturates
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (i_valid) begin
      if (i_last) begin
        col <= '0;
        row <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        if (row != '1) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Horizontal shift registers: index 0 holds the newest column of each tap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned t = 0; t < WIN_ROWS; t++)
        for (int unsigned k = 0; k < WIN_COLS; k++)
          sr[t][k] <= '0;
    end else if (i_valid) begin
      sr[0][0] <= tap0;
      sr[1][0] <= tap1;
      sr[2][0] <= tap2;
      for (int unsigned t = 0; t < WIN_ROWS; t++)
        for (int unsigned k = 1; k < WIN_COLS; k++)
          sr[t][k] <= sr[t][k-1];
    end
  end

  // Window is a fixed rewiring of the registered shift taps: oldest row/column at r=0/c=0
  always_comb begin
    o_window = '0;
    for (int unsigned r = 0; r < WIN_ROWS; r++)
      for (int unsigned c = 0; c < WIN_COLS; c++)
        o_window[DW*win_idx(r, c) +: DW] = sr[WIN_ROWS-1-r][WIN_COLS-1-c];
  end

  // Registered strobes, one cycle after the accepted beat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= emit;
      o_last       <= emit && i_last;
      o_frame_done <= i_valid && i_last;
    end
  end

`ifdef CONV_WIN_CNT_EN
  // Per-frame window count, cleared by the first beat of the following frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_win_count <= '0;
    end else if (i_valid && (row == '0) && (col == '0)) begin
      o_win_count <= '0;
    end else if (emit) begin
      o_win_count <= o_win_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed, table-driven bench for conv_window_gen (IMG_W=4 and IMG_W=3 instances).
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        v4, l4, v3, l3;
  logic [7:0]  d4, d3;
  logic [71:0] w4, w3;
  logic        ov4, ol4, od4, ov3, ol3, od3;
`ifdef CONV_WIN_CNT_EN
  logic [19:0] cnt4, cnt3;
`endif

  always #5 clk = ~clk;

  conv_window_gen #(.IMG_W(4), .DW(8), .ROW_W(12)) dut4 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (v4),
    .i_data       (d4),
    .i_last       (l4),
    .o_window     (w4),
    .o_valid      (ov4),
    .o_last       (ol4),
    .o_frame_done (od4)
`ifdef CONV_WIN_CNT_EN
    ,
    .o_win_count  (cnt4)
`endif
  );

  conv_window_gen #(.IMG_W(3), .DW(8), .ROW_W(12)) dut3 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (v3),
    .i_data       (d3),
    .i_last       (l3),
    .o_window     (w3),
    .o_valid      (ov3),
    .o_last       (ol3),
    .o_frame_done (od3)
`ifdef CONV_WIN_CNT_EN
    ,
    .o_win_count  (cnt3)
`endif
  );

  typedef struct {
    bit          sel3;
    bit          v;
    bit          l;
    logic [7:0]  d;
    bit          ev;
    bit          el;
    bit          ed;
    logic [71:0] ew;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nmis = 0;

  // Element k=r*3+c of a window whose top-left pixel is (r0,c0) in a frame of pixels base+idx
  function automatic logic [71:0] mk_win(int base, int w, int r0, int c0);
    logic [71:0] x;
    x = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        x[8*(r*3+c) +: 8] = 8'(base + (r0 + r) * w + c0 + c);
    return x;
  endfunction

  function automatic vec_t mk_vec(bit sel3, int base, int w, int p, bit is_last);
    vec_t e;
    int r, c;
    r = p / w;
    c = p % w;
    e.sel3 = sel3;
    e.v    = 1'b1;
    e.d    = 8'(base + p);
    e.l    = is_last;
    e.ev   = (r >= 2) && (c >= 2);
    e.el   = e.ev && is_last;
    e.ed   = is_last;
    e.ew   = e.ev ? mk_win(base, w, r - 2, c - 2) : '0;
    return e;
  endfunction

  // Idle beats carry junk data and i_last=1 to show they are ignored
  function automatic vec_t mk_idle(bit sel3);
    vec_t e;
    e.sel3 = sel3;
    e.v = 1'b0; e.l = 1'b1; e.d = 8'hEE;
    e.ev = 1'b0; e.el = 1'b0; e.ed = 1'b0; e.ew = '0;
    return e;
  endfunction

  task automatic push_frame(bit sel3, int base, int w, int npix, bit gap, bit with_last);
    for (int p = 0; p < npix; p++) begin
      if (gap) vq.push_back(mk_idle(sel3));
      vq.push_back(mk_vec(sel3, base, w, p, with_last && (p == npix - 1)));
    end
  endtask

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      nmis++;
    end
  endtask

  task automatic apply(input vec_t e);
    logic        av, al, ad;
    logic [71:0] aw;
    @(negedge clk);
    if (e.sel3) begin
      v3 = e.v; d3 = e.d; l3 = e.l; v4 = 1'b0; l4 = 1'b0;
    end else begin
      v4 = e.v; d4 = e.d; l4 = e.l; v3 = 1'b0; l3 = 1'b0;
    end
    @(posedge clk);
    #1;
    nvec++;
    if (e.sel3) begin
      av = ov3; al = ol3; ad = od3; aw = w3;
    end else begin
      av = ov4; al = ol4; ad = od4; aw = w4;
    end
    chk("o_valid", 72'(av), 72'(e.ev));
    chk("o_last", 72'(al), 72'(e.el));
    chk("o_frame_done", 72'(ad), 72'(e.ed));
    if (e.ev) chk("o_window", aw, e.ew);
  endtask

  initial begin
    int idx;
`ifdef CONV_WIN_CNT_EN
    int ecnt;
    vec_t e;
`endif
    rst = 1'b1;
    v4 = 1'b0; l4 = 1'b0; d4 = '0;
    v3 = 1'b0; l3 = 1'b0; d3 = '0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    chk("reset o_window", w4, '0);
    chk("reset o_valid", 72'({ov4, ov3}), '0);
    chk("reset o_last", 72'({ol4, ol3}), '0);
    chk("reset o_frame_done", 72'({od4, od3}), '0);
    @(negedge clk);
    rst = 1'b0;

    // 4x4 frame 0..15, continuous; first window hand-written
    idx = vq.size() + 10;
    push_frame(1'b0, 0, 4, 16, 1'b0, 1'b1);
    vq[idx].ew = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    // Same frame with an idle beat before every pixel
    push_frame(1'b0, 0, 4, 16, 1'b1, 1'b1);
    // Truncated at pixel 9 (row 2, col 1): no windows, frame_done only
    push_frame(1'b0, 0, 4, 10, 1'b0, 1'b1);
    // Following full frame 100..115; first window hand-written
    idx = vq.size() + 10;
    push_frame(1'b0, 100, 4, 16, 1'b0, 1'b1);
    vq[idx].ew = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
    // IMG_W=3, 3x5 frame: windows on pixels 8, 11, 14
    push_frame(1'b1, 0, 3, 15, 1'b0, 1'b1);

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Reset mid-frame after pixel 11 of a 4x4 frame
    vq.delete();
    push_frame(1'b0, 60, 4, 12, 1'b0, 1'b0);
    for (int i = 0; i < vq.size(); i++) apply(vq[i]);
    #2;
    rst = 1'b1;
    v4 = 1'b0; l4 = 1'b0;
    #1;
    nvec++;
    chk("async reset o_valid", 72'(ov4), '0);
    chk("async reset o_window", w4, '0);
    chk("async reset o_last", 72'(ol4), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(mk_idle(1'b0));
    vq.delete();
    push_frame(1'b0, 40, 4, 16, 1'b0, 1'b1);
    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

`ifdef CONV_WIN_CNT_EN
    // Two back-to-back frames: count climbs to 4, holds, restarts at 1
    ecnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 16; p++) begin
        e = mk_vec(1'b0, 50 * f, 4, p, p == 15);
        apply(e);
        if (p == 0) ecnt = 0;
        if (e.ev) ecnt++;
        chk("o_win_count", 72'(cnt4), 72'(ecnt));
      end
    end
    apply(mk_idle(1'b0));
    chk("o_win_count hold", 72'(cnt4), 72'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Builds 3x3 pixel windows from a raster-order byte stream, one byte per accepted beat.
- Sits between the input packet buffer and conv_engine.
- Consumes the buffer's data/enable stream and produces one 72-bit window per interior pixel, plus frame-end markers.
- Has no backpressure, because conv_engine accepts data every cycle.

Parameters:
IMG_W, 16, image row width in pixels (legal range 3..256)
DW, 8, pixel width in bits
ROW_W, 12, row counter width (enough for 4095-byte packets)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  pixel beat valid
i_data  in  DW  pixel value
i_last  in  1  last pixel of frame, qualified by i_valid
o_window  out  9*DW  3x3 window, element k = r*3+c at [DW*k +: DW]
o_valid  out  1  window valid, single-cycle per window
o_last  out  1  window is the last of the frame
o_frame_done  out  1  one-cycle pulse after any accepted i_last

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_window=0, o_valid=0, o_last=0, o_frame_done=0, col=0, row=0. Line-buffer contents are don't-care.
- Accepted beat = i_valid=1. With i_valid=0, counters and line buffers hold, and o_valid/o_last/o_frame_done are 0 the next cycle.
- Column counter: 0..IMG_W-1. At IMG_W-1 it wraps to 0 and row increments. Row saturates at 2^ROW_W-1.
- Line buffers: two cascaded row delays, each exactly IMG_W accepted beats deep. They advance only on accepted beats.
  - Tap 0 is the incoming pixel (row n).
  - Tap 1 is the previous row (n-1).
  - Tap 2 is two rows back (n-2).
- Shift registers: three 3-deep horizontal shift registers, one per tap, also advance on accepted beats.
- Window orientation: r=0 is the oldest row (n-2); c=0 is the oldest column (col-2). Element 8 is the current input pixel.
- Emission: when a beat is accepted at (row>=2, col>=2), o_valid=1 in the next cycle. o_window is then centred on (row-1, col-1). Latency is 1 cycle from bottom-right pixel to window.
- Edge pixels: columns 0..1 and rows 0..1 produce no window (valid-convolution mode). A frame of W x H yields (W-2)*(H-2) windows.
- o_last: asserted with o_valid when the emitting beat also carried i_last.
- o_frame_done: pulses one cycle after any accepted i_last, whether or not a window was emitted.
- i_last handling: on an accepted i_last beat, col and row clear to 0 at the clock edge. The next beat is treated as pixel (0,0) of a new frame; no idle cycle is required between frames.
- Truncated frame: i_last at col != IMG_W-1 is a truncated frame. Windows already emitted stand, and counters reset as above. o_last is asserted only if that beat emitted a window.
- Reset mid-frame: all state is cleared asynchronously, and outputs drop in the same cycle reset asserts. The partial frame is discarded.
- Width rules: no arithmetic on pixels; windows carry raw pixel bytes. Counters are unsigned, with col width $clog2(IMG_W).

Optional Feature:
- Macro: CONV_WIN_CNT_EN.
- When defined: adds output o_win_count (ROW_W+8 bits).
  - Increments on each o_valid and holds its final value through the o_frame_done cycle.
  - Clears on the first accepted beat of the next frame and on reset.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package conv_pkg:
  - DW localparam
  - typedef pixel_t (logic [DW-1:0])
  - typedef window_t (pixel_t [8:0])
  - constants WIN_ROWS=3, WIN_COLS=3
  - function win_idx(r,c) returning r*3+c
- Sub-module conv_line_delay: a single IMG_W-deep enable-gated delay line.
  - Implemented as a circular RAM with one pointer, read-before-write.
  - Instantiated twice in cascade.

Test Plan:
- IMG_W=4, 4x4 frame, pixels 0..15, i_valid continuous, i_last on 15:
  - 4 windows, centred on 5, 6, 9, 10.
  - First window is elements 0,1,2,4,5,6,8,9,10.
  - o_last only on the 4th window; o_frame_done one cycle after pixel 15.
- Same frame with i_valid=0 on every other cycle: identical window contents and order; o_valid never asserted in a cycle following an idle beat.
- IMG_W=4, i_last at pixel 9 (row 2, col 1): zero windows and o_frame_done pulses. A following full 4x4 frame 100..115 yields a first window of 100,101,102,104,105,106,108,109,110.
- Reset asserted after pixel 11 of a 4x4 frame:
  - outputs 0 immediately, no further windows;
  - a new frame afterwards produces the correct 4 windows.
- IMG_W=3, frame of 3x5 = 15 pixels: 3 windows, the last with o_last=1.
- With CONV_WIN_CNT_EN defined, two back-to-back 4x4 frames: o_win_count reaches 4, holds, then restarts at 1 on the second frame's first window.
